// File: rtl/bus_ctrl_pkg.sv
// Shared types and decode helpers for the system bus cycle controller.
// Cycle-type encoding is {is_mem, is_write}, so bit 0 is the write flag.
package bus_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      T1   = 3'd1,
      T2   = 3'd2,
      TW   = 3'd3,
      T3   = 3'd4,
      T4   = 3'd5
   } bus_state_t;

   typedef enum logic [1:0] {
      IO_READ   = 2'd0,
      IO_WRITE  = 2'd1,
      MEM_READ  = 2'd2,
      MEM_WRITE = 2'd3
   } cycle_type_t;

   function automatic cycle_type_t make_cycle_type(input logic is_io, input logic is_write);
      return cycle_type_t'({~is_io, is_write});
   endfunction

   // Returns {IOR_N, IOW_N, MEMR_N, MEMW_N}; all high unless the strobe window is open.
   function automatic logic [3:0] strobe_decode(input cycle_type_t ctype, input logic active);
      logic [3:0] s;
      s = 4'b1111;
      if (active) begin
         case (ctype)
            IO_READ:   s = 4'b0111;
            IO_WRITE:  s = 4'b1011;
            MEM_READ:  s = 4'b1101;
            MEM_WRITE: s = 4'b1110;
            default:   s = 4'b1111;
         endcase
      end
      return s;
   endfunction

endpackage

// File: rtl/bus_grant_arbiter.sv
// Combinational request arbiter: fixed lowest-index priority or rotating from ptr.
// Zero latency; the pointer register is owned by the caller.
module bus_grant_arbiter #(
   parameter int NUM_MASTERS = 2,
   parameter int PTR_W       = 1
) (
   input  logic [NUM_MASTERS-1:0] req,
   input  logic                   round_robin,
   input  logic [PTR_W-1:0]       ptr,
   output logic [NUM_MASTERS-1:0] winner,
   output logic [PTR_W-1:0]       next_ptr
);

   int   start_idx;
   int   cand;
   logic found;

   always_comb begin
      winner    = '0;
      next_ptr  = ptr;
      found     = 1'b0;
      cand      = 0;
      start_idx = round_robin ? int'(ptr) : 0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         cand = (start_idx + k) % NUM_MASTERS;
         if (!found && req[cand]) begin
            found          = 1'b1;
            winner[cand]   = 1'b1;
            next_ptr       = PTR_W'((cand + 1) % NUM_MASTERS);
         end
      end
   end

endmodule

// File: rtl/system_bus_controller.sv
// Multi-master 8088-style bus cycle controller: arbitrates, then runs T1-T4 with wait states.
// A granted cycle always runs to completion; READY low stretches it in TW indefinitely.
module system_bus_controller
   import bus_ctrl_pkg::*;
#(
   parameter int NUM_MASTERS     = 2,
   parameter int ADDR_WIDTH      = 20,
   parameter int DATA_WIDTH      = 8,
   parameter int IO_WAIT_STATES  = 1,
   parameter int MEM_WAIT_STATES = 0,
   parameter int MAX_WAIT        = 7,
   parameter int ROUND_ROBIN     = 0
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              cpu_clock_posedge,
   input  logic                              cpu_clock_negedge,
   input  logic [NUM_MASTERS-1:0]            req,
   input  logic [NUM_MASTERS-1:0]            req_write,
   input  logic [NUM_MASTERS-1:0]            req_io,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_MASTERS*DATA_WIDTH-1:0] req_wdata,
   input  logic                              READY,
   input  logic [DATA_WIDTH-1:0]             bus_data_in,
   output logic [NUM_MASTERS-1:0]            grant,
   output logic [NUM_MASTERS-1:0]            ack,
   output logic [DATA_WIDTH-1:0]             rdata,
   output logic [ADDR_WIDTH-1:0]             bus_address,
   output logic [DATA_WIDTH-1:0]             bus_data_out,
   output logic                              ALE,
   output logic                              IOR_N,
   output logic                              IOW_N,
   output logic                              MEMR_N,
   output logic                              MEMW_N,
   output logic                              IO_E,
   output logic                              R_OR_DT
);

   localparam int PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

   if (IO_WAIT_STATES > MAX_WAIT || MEM_WAIT_STATES > MAX_WAIT) begin : g_bad_wait
      $error("wait-state parameter exceeds MAX_WAIT");
   end
   if (NUM_MASTERS < 1 || NUM_MASTERS > 8) begin : g_bad_masters
      $error("NUM_MASTERS must be 1..8");
   end

   bus_state_t               state_q, state_d;
   cycle_type_t              ctype_q, ctype_d;
   logic [NUM_MASTERS-1:0]   grant_q, grant_d;
   logic [NUM_MASTERS-1:0]   ack_q, ack_d;
   logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
   logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
   logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d, cnt_dec;
   logic                     strobe_on_q, strobe_on_d;
   logic [PTR_W-1:0]         ptr_q, ptr_d;

   logic [NUM_MASTERS-1:0]   winner;
   logic [PTR_W-1:0]         next_ptr;
   logic [ADDR_WIDTH-1:0]    sel_addr;
   logic [DATA_WIDTH-1:0]    sel_wdata;
   logic                     sel_write, sel_io, load, is_read;

   bus_grant_arbiter #(
      .NUM_MASTERS (NUM_MASTERS),
      .PTR_W       (PTR_W)
   ) u_arb (
      .req         (req),
      .round_robin (ROUND_ROBIN != 0),
      .ptr         (ptr_q),
      .winner      (winner),
      .next_ptr    (next_ptr)
   );

   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      sel_write = 1'b0;
      sel_io    = 1'b0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (winner[i]) begin
            sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            sel_write = req_write[i];
            sel_io    = req_io[i];
         end
      end
   end

   assign is_read = (ctype_q == IO_READ) || (ctype_q == MEM_READ);

   always_comb begin
      state_d     = state_q;
      ctype_d     = ctype_q;
      grant_d     = grant_q;
      ack_d       = '0;
      rdata_d     = rdata_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      cnt_d       = cnt_q;
      strobe_on_d = strobe_on_q;
      ptr_d       = ptr_q;
      load        = 1'b0;
      cnt_dec     = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;

      // Posedge work takes precedence, so a coincident negedge enable is dropped.
      case (state_q)
         IDLE: load = cpu_clock_posedge && (req != '0);
         T1:   if (cpu_clock_posedge) state_d = T2;
         T2: begin
            if (cpu_clock_posedge) state_d = (cnt_q == '0 && READY) ? T3 : TW;
            else if (cpu_clock_negedge) strobe_on_d = 1'b1;
         end
         TW: begin
            if (cpu_clock_posedge) begin
               cnt_d = cnt_dec;
               if (cnt_dec == '0 && READY) state_d = T3;
            end
         end
         T3: begin
            if (cpu_clock_posedge) begin
               ack_d       = grant_q;
               strobe_on_d = 1'b0;
               state_d     = T4;
               if (is_read) rdata_d = bus_data_in;
            end
         end
         T4: begin
            if (cpu_clock_posedge) begin
               grant_d = '0;
               state_d = IDLE;
               load    = (req != '0);
            end
         end
         default: state_d = IDLE;
      endcase

      // Starting straight from T4 gives back-to-back cycles with no idle clock.
      if (load) begin
         state_d = T1;
         grant_d = winner;
         addr_d  = sel_addr;
         wdata_d = sel_wdata;
         ctype_d = make_cycle_type(sel_io, sel_write);
         cnt_d   = sel_io ? CNT_W'(IO_WAIT_STATES) : CNT_W'(MEM_WAIT_STATES);
         ptr_d   = next_ptr;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         ctype_q     <= IO_READ;
         grant_q     <= '0;
         ack_q       <= '0;
         rdata_q     <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         cnt_q       <= '0;
         strobe_on_q <= 1'b0;
         ptr_q       <= '0;
      end else begin
         state_q     <= state_d;
         ctype_q     <= ctype_d;
         grant_q     <= grant_d;
         ack_q       <= ack_d;
         rdata_q     <= rdata_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         cnt_q       <= cnt_d;
         strobe_on_q <= strobe_on_d;
         ptr_q       <= ptr_d;
      end
   end

   assign grant        = grant_q;
   assign ack          = ack_q;
   assign rdata        = rdata_q;
   assign bus_address  = addr_q;
   assign bus_data_out = wdata_q;
   assign ALE          = (state_q == T1);
   assign IO_E         = (state_q == T2) || (state_q == TW) || (state_q == T3);
   assign R_OR_DT      = is_read && (state_q != IDLE);
   assign {IOR_N, IOW_N, MEMR_N, MEMW_N} = strobe_decode(ctype_q, strobe_on_q);

endmodule

// File: tb/tb_system_bus_controller.sv
// Directed bench: one rotating-priority and one fixed-priority controller share stimulus.
// CPU clock enables run at 1/4 of the system clock; outputs sampled 1 time unit after posedge.
module tb_system_bus_controller;

   localparam int N  = 3;
   localparam int AW = 20;
   localparam int DW = 8;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              cpu_clock_posedge = 1'b0;
   logic              cpu_clock_negedge = 1'b0;
   logic [N-1:0]      req = '0, req_write = '0, req_io = '0;
   logic [N*AW-1:0]   req_addr = '0;
   logic [N*DW-1:0]   req_wdata = '0;
   logic              READY = 1'b1;
   logic [DW-1:0]     bus_data_in = '0;

   logic [N-1:0]  grant, ack, fp_grant, fp_ack;
   logic [DW-1:0] rdata, bus_data_out, fp_rdata, fp_bus_data_out;
   logic [AW-1:0] bus_address, fp_bus_address;
   logic ALE, IOR_N, IOW_N, MEMR_N, MEMW_N, IO_E, R_OR_DT;
   logic fp_ALE, fp_IOR_N, fp_IOW_N, fp_MEMR_N, fp_MEMW_N, fp_IO_E, fp_R_OR_DT;

   system_bus_controller #(
      .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .IO_WAIT_STATES(1),
      .MEM_WAIT_STATES(0), .MAX_WAIT(7), .ROUND_ROBIN(1)
   ) dut (
      .clock(clock), .reset(reset), .cpu_clock_posedge(cpu_clock_posedge),
      .cpu_clock_negedge(cpu_clock_negedge), .req(req), .req_write(req_write), .req_io(req_io),
      .req_addr(req_addr), .req_wdata(req_wdata), .READY(READY), .bus_data_in(bus_data_in),
      .grant(grant), .ack(ack), .rdata(rdata), .bus_address(bus_address),
      .bus_data_out(bus_data_out), .ALE(ALE), .IOR_N(IOR_N), .IOW_N(IOW_N),
      .MEMR_N(MEMR_N), .MEMW_N(MEMW_N), .IO_E(IO_E), .R_OR_DT(R_OR_DT)
   );

   system_bus_controller #(
      .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .IO_WAIT_STATES(1),
      .MEM_WAIT_STATES(0), .MAX_WAIT(7), .ROUND_ROBIN(0)
   ) dut_fp (
      .clock(clock), .reset(reset), .cpu_clock_posedge(cpu_clock_posedge),
      .cpu_clock_negedge(cpu_clock_negedge), .req(req), .req_write(req_write), .req_io(req_io),
      .req_addr(req_addr), .req_wdata(req_wdata), .READY(READY), .bus_data_in(bus_data_in),
      .grant(fp_grant), .ack(fp_ack), .rdata(fp_rdata), .bus_address(fp_bus_address),
      .bus_data_out(fp_bus_data_out), .ALE(fp_ALE), .IOR_N(fp_IOR_N), .IOW_N(fp_IOW_N),
      .MEMR_N(fp_MEMR_N), .MEMW_N(fp_MEMW_N), .IO_E(fp_IO_E), .R_OR_DT(fp_R_OR_DT)
   );

   always #5 clock = ~clock;

   logic [1:0] phase = 2'd0;
   always @(negedge clock) begin
      phase = phase + 2'd1;
      cpu_clock_posedge = (phase == 2'd0);
      cpu_clock_negedge = (phase == 2'd2);
   end

   int checks = 0;
   int failures = 0;

   int ale_cnt, ioe_cnt, ioe_first, strb_lo_cnt, strb_first, ack_idx, ack_cnt, end_idx;
   logic [3:0]   strb_seen;
   logic [N-1:0] ack_val;
   logic         ale0, rdt0;

   task automatic wait_cpu_pos();
      @(posedge clock);
      while (!cpu_clock_posedge) @(posedge clock);
      #1;
   endtask

   // Records n samples, index 0 being the current time (just after T1 entry).
   task automatic capture(input int n);
      logic [3:0] s;
      ale_cnt = 0; ioe_cnt = 0; strb_lo_cnt = 0; ack_cnt = 0;
      ioe_first = -1; strb_first = -1; ack_idx = -1; end_idx = -1;
      strb_seen = '0; ack_val = '0;
      ale0 = ALE; rdt0 = R_OR_DT;
      for (int i = 0; i < n; i++) begin
         if (i > 0) begin @(posedge clock); #1; end
         s = ~{IOR_N, IOW_N, MEMR_N, MEMW_N};
         if (ALE) ale_cnt++;
         if (IO_E) begin ioe_cnt++; if (ioe_first < 0) ioe_first = i; end
         if (s != 4'b0000) begin strb_lo_cnt++; if (strb_first < 0) strb_first = i; end
         strb_seen = strb_seen | s;
         if (ack != '0) begin ack_cnt++; if (ack_idx < 0) begin ack_idx = i; ack_val = ack; end end
         if (i > 0 && grant == '0 && end_idx < 0) end_idx = i;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      checks++; if (grant !== 3'b000) begin failures++; $display("FAIL rst_grant got=%b exp=000", grant); end
      checks++; if (ack !== 3'b000) begin failures++; $display("FAIL rst_ack got=%b exp=000", ack); end
      checks++; if ({IOR_N, IOW_N, MEMR_N, MEMW_N} !== 4'hF) begin failures++; $display("FAIL rst_strobes got=%b exp=1111", {IOR_N, IOW_N, MEMR_N, MEMW_N}); end
      checks++; if ({ALE, IO_E, R_OR_DT} !== 3'b000) begin failures++; $display("FAIL rst_ctl got=%b exp=000", {ALE, IO_E, R_OR_DT}); end
      checks++; if ({bus_address, bus_data_out, rdata} !== '0) begin failures++; $display("FAIL rst_data got=%h/%h/%h exp=0", bus_address, bus_data_out, rdata); end
      reset = 1'b0;
      repeat (8) @(posedge clock);
      #1;
      checks++; if (grant !== 3'b000 || ALE !== 1'b0) begin failures++; $display("FAIL idle_no_req grant=%b ale=%b exp=000/0", grant, ALE); end
   endtask

   task automatic test_mem_read();
      req_addr[0 +: AW] = 20'hF0000; bus_data_in = 8'hA5;
      req_write = '0; req_io = '0; req = 3'b001;
      wait_cpu_pos();
      req = '0;
      checks++; if (grant !== 3'b001) begin failures++; $display("FAIL rd_grant got=%b exp=001", grant); end
      checks++; if (bus_address !== 20'hF0000) begin failures++; $display("FAIL rd_addr got=%h exp=f0000", bus_address); end
      capture(24);
      checks++; if (ale0 !== 1'b1 || ale_cnt != 4) begin failures++; $display("FAIL rd_ale got=%b/%0d exp=1/4", ale0, ale_cnt); end
      checks++; if (rdt0 !== 1'b1) begin failures++; $display("FAIL rd_r_or_dt got=%b exp=1", rdt0); end
      checks++; if (strb_seen !== 4'b0010) begin failures++; $display("FAIL rd_strobe_sel got=%b exp=0010", strb_seen); end
      checks++; if (strb_first != 6 || strb_lo_cnt != 6) begin failures++; $display("FAIL rd_memr_window got=%0d/%0d exp=6/6", strb_first, strb_lo_cnt); end
      checks++; if (ioe_first != 4 || ioe_cnt != 8) begin failures++; $display("FAIL rd_io_e got=%0d/%0d exp=4/8", ioe_first, ioe_cnt); end
      checks++; if (ack_idx != 12 || ack_cnt != 1 || ack_val !== 3'b001) begin failures++; $display("FAIL rd_ack got=%0d/%0d/%b exp=12/1/001", ack_idx, ack_cnt, ack_val); end
      checks++; if (end_idx != 16) begin failures++; $display("FAIL rd_len got=%0d exp=16", end_idx); end
      checks++; if (rdata !== 8'hA5) begin failures++; $display("FAIL rd_rdata got=%h exp=a5", rdata); end
      bus_data_in = '0;
   endtask

   task automatic test_io_write();
      req_addr[0 +: AW] = 20'h00061; req_wdata[0 +: DW] = 8'h3C;
      req_write = 3'b001; req_io = 3'b001; req = 3'b001;
      wait_cpu_pos();
      req = '0;
      checks++; if (bus_data_out !== 8'h3C || bus_address !== 20'h00061) begin failures++; $display("FAIL wr_latch got=%h/%h exp=3c/00061", bus_data_out, bus_address); end
      capture(28);
      checks++; if (rdt0 !== 1'b0) begin failures++; $display("FAIL wr_r_or_dt got=%b exp=0", rdt0); end
      checks++; if (strb_seen !== 4'b0100) begin failures++; $display("FAIL wr_strobe_sel got=%b exp=0100", strb_seen); end
      checks++; if (strb_first != 6 || strb_lo_cnt != 10) begin failures++; $display("FAIL wr_iow_window got=%0d/%0d exp=6/10", strb_first, strb_lo_cnt); end
      checks++; if (ioe_first != 4 || ioe_cnt != 12) begin failures++; $display("FAIL wr_io_e got=%0d/%0d exp=4/12", ioe_first, ioe_cnt); end
      checks++; if (ack_idx != 16 || end_idx != 20) begin failures++; $display("FAIL wr_len ack=%0d end=%0d exp=16/20", ack_idx, end_idx); end
   endtask

   task automatic test_ready_extend();
      req_addr[0 +: AW] = 20'h0ABCD; req_wdata[0 +: DW] = 8'h5A;
      req_write = 3'b001; req_io = 3'b000; req = 3'b001;
      wait_cpu_pos();
      req = '0; READY = 1'b0;
      fork
         capture(36);
         begin #170; READY = 1'b1; end
      join
      checks++; if (strb_seen !== 4'b0001) begin failures++; $display("FAIL rdy_strobe_sel got=%b exp=0001", strb_seen); end
      checks++; if (strb_first != 6 || strb_lo_cnt != 18) begin failures++; $display("FAIL rdy_memw_window got=%0d/%0d exp=6/18", strb_first, strb_lo_cnt); end
      checks++; if (ack_idx != 24 || ack_cnt != 1) begin failures++; $display("FAIL rdy_ack got=%0d/%0d exp=24/1", ack_idx, ack_cnt); end
      checks++; if (end_idx != 28) begin failures++; $display("FAIL rdy_len got=%0d exp=28", end_idx); end
   endtask

   task automatic test_req_drop();
      req_addr[AW +: AW] = 20'h12345; bus_data_in = 8'h7E;
      req_write = '0; req_io = '0; req = 3'b010;
      wait_cpu_pos();
      checks++; if (grant !== 3'b010) begin failures++; $display("FAIL drop_grant got=%b exp=010", grant); end
      repeat (5) @(posedge clock);
      #1;
      req = '0;
      checks++; if (grant !== 3'b010 || IO_E !== 1'b1) begin failures++; $display("FAIL drop_in_t2 grant=%b io_e=%b exp=010/1", grant, IO_E); end
      capture(20);
      checks++; if (ack_idx != 7 || ack_val !== 3'b010) begin failures++; $display("FAIL drop_ack got=%0d/%b exp=7/010", ack_idx, ack_val); end
      checks++; if (end_idx != 11) begin failures++; $display("FAIL drop_len got=%0d exp=11", end_idx); end
      checks++; if (rdata !== 8'h7E || bus_address !== 20'h12345) begin failures++; $display("FAIL drop_data got=%h/%h exp=7e/12345", rdata, bus_address); end
      bus_data_in = '0;
   endtask

   task automatic test_reset_mid_cycle();
      req_addr[0 +: AW] = 20'h00060; req_write = '0; req_io = 3'b001; req = 3'b001;
      wait_cpu_pos();
      req = '0;
      repeat (9) @(posedge clock);
      #1;
      checks++; if (IOR_N !== 1'b0 || IO_E !== 1'b1) begin failures++; $display("FAIL mid_tw ior_n=%b io_e=%b exp=0/1", IOR_N, IO_E); end
      reset = 1'b1;
      @(posedge clock);
      #1;
      checks++; if ({IOR_N, IOW_N, MEMR_N, MEMW_N} !== 4'hF) begin failures++; $display("FAIL mid_strobes got=%b exp=1111", {IOR_N, IOW_N, MEMR_N, MEMW_N}); end
      checks++; if (grant !== 3'b000 || ack !== 3'b000) begin failures++; $display("FAIL mid_grant_ack got=%b/%b exp=000/000", grant, ack); end
      checks++; if ({ALE, IO_E, R_OR_DT} !== 3'b000) begin failures++; $display("FAIL mid_ctl got=%b exp=000", {ALE, IO_E, R_OR_DT}); end
      reset = 1'b0;
      capture(24);
      checks++; if (ack_cnt != 0 || ale_cnt != 0 || strb_lo_cnt != 0) begin failures++; $display("FAIL mid_idle ack=%0d ale=%0d strb=%0d exp=0/0/0", ack_cnt, ale_cnt, strb_lo_cnt); end
   endtask

   task automatic test_round_robin();
      logic [N-1:0] exp_rr [4];
      logic [N-1:0] rr_seq [4];
      logic [N-1:0] fp_seq [3];
      int rr_t [4];
      int na, nf;
      exp_rr = '{3'b001, 3'b010, 3'b100, 3'b001};
      na = 0; nf = 0;
      for (int k = 0; k < 4; k++) begin rr_seq[k] = '0; rr_t[k] = 0; end
      for (int k = 0; k < 3; k++) fp_seq[k] = '0;
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      req_write = '0; req_io = '0; req = 3'b111;
      for (int i = 0; i < 80; i++) begin
         @(posedge clock);
         #1;
         if (ack != '0 && na < 4) begin rr_seq[na] = ack; rr_t[na] = i; na++; end
         if (fp_ack != '0 && nf < 3) begin fp_seq[nf] = fp_ack; nf++; end
      end
      req = '0;
      repeat (48) @(posedge clock);
      #1;
      checks++; if (na != 4) begin failures++; $display("FAIL rr_count got=%0d exp=4", na); end
      for (int k = 0; k < 4; k++) begin
         checks++; if (rr_seq[k] !== exp_rr[k]) begin failures++; $display("FAIL rr_grant%0d got=%b exp=%b", k, rr_seq[k], exp_rr[k]); end
      end
      for (int k = 0; k < 3; k++) begin
         checks++; if (rr_t[k+1] - rr_t[k] != 16) begin failures++; $display("FAIL rr_gap%0d got=%0d exp=16", k, rr_t[k+1] - rr_t[k]); end
      end
      checks++; if (nf != 3) begin failures++; $display("FAIL fp_count got=%0d exp=3", nf); end
      for (int k = 0; k < 3; k++) begin
         checks++; if (fp_seq[k] !== 3'b001) begin failures++; $display("FAIL fp_grant%0d got=%b exp=001", k, fp_seq[k]); end
      end
      checks++; if (grant !== 3'b000 || fp_grant !== 3'b000) begin failures++; $display("FAIL rr_drain got=%b/%b exp=000/000", grant, fp_grant); end
   endtask

   initial begin
      test_reset();
      test_mem_read();
      test_io_write();
      test_ready_extend();
      test_req_drop();
      test_reset_mid_cycle();
      test_round_robin();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

endmodule

// File: doc/system_bus_controller.md
# system_bus_controller

Parametrised multi-master bus cycle controller for the KFPCJr system bus. It arbitrates N bus masters (CPU, DMA, video refresh), runs one 8088-style T1–T4 cycle per grant with configurable wait states and READY extension, and drives the active-low command strobes, ALE and the data transceiver enable. All timing is qualified by the `cpu_clock_posedge` / `cpu_clock_negedge` enables on the single system clock.

## Interface
Parameters:
- `NUM_MASTERS`, 2, number of requesting masters, 1..8; index 0 is the CPU.
- `ADDR_WIDTH`, 20, bus address width.
- `DATA_WIDTH`, 8, bus data width.
- `IO_WAIT_STATES`, 1, fixed wait states inserted on I/O cycles.
- `MEM_WAIT_STATES`, 0, fixed wait states inserted on memory cycles.
- `MAX_WAIT`, 7, upper bound for both wait-state parameters; sizes the wait counter.
- `ROUND_ROBIN`, 0, 0 = fixed priority with lowest index winning; 1 = rotating priority.

Ports:
- `clock` in 1: system clock; single clock domain.
- `reset` in 1: synchronous, active-high.
- `cpu_clock_posedge` in 1: one-clock enable marking a CPU clock rising edge; T-state boundary.
- `cpu_clock_negedge` in 1: one-clock enable marking a CPU clock falling edge.
- `req` in NUM_MASTERS: per-master request levels.
- `req_write` in NUM_MASTERS: 1 = write, 0 = read.
- `req_io` in NUM_MASTERS: 1 = I/O cycle, 0 = memory cycle.
- `req_addr` in NUM_MASTERS*ADDR_WIDTH: flattened addresses; master i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- `req_wdata` in NUM_MASTERS*DATA_WIDTH: flattened write data, packed the same way.
- `READY` in 1: bus ready; low extends the cycle.
- `bus_data_in` in DATA_WIDTH: read data from the bus.
- `grant` out NUM_MASTERS: one-hot grant; held from T1 through T4.
- `ack` out NUM_MASTERS: one-clock completion pulse to the granted master.
- `rdata` out DATA_WIDTH: read data latched at end of T3.
- `bus_address` out ADDR_WIDTH: latched cycle address.
- `bus_data_out` out DATA_WIDTH: latched write data.
- `ALE` out 1: address latch enable.
- `IOR_N`, `IOW_N`, `MEMR_N`, `MEMW_N` out 1 each: command strobes, active low.
- `IO_E` out 1: data transceiver enable.
- `R_OR_DT` out 1: 1 during read cycles.

## Operation
States are IDLE, T1, T2, TW, T3, T4. Every state change happens on a clock where `cpu_clock_posedge` = 1.
- IDLE: if `req` ≠ 0, select a winner, register the cycle, and enter T1.
  - Registered fields: `grant`, `bus_address`, `bus_data_out`, cycle type, and the wait counter (loaded with IO_WAIT_STATES or MEM_WAIT_STATES).
- T1: `ALE` = 1. Advance to T2.
- T2: the selected strobe goes low on the first `cpu_clock_negedge` inside T2.
  - Strobe selection: read+IO → `IOR_N`, write+IO → `IOW_N`, read+mem → `MEMR_N`, write+mem → `MEMW_N`.
  - At the closing posedge: if counter = 0 and `READY` = 1, go to T3; otherwise go to TW.
- TW: at each posedge, decrement the counter if nonzero. Go to T3 when the counter is 0 and `READY` = 1. There is no timeout.
- T3: the strobe stays asserted. At the closing posedge, latch `rdata` (reads only), pulse `ack` for one clock, and go to T4.
- T4: all strobes high. At the closing posedge, clear `grant` and return to IDLE.
- `IO_E` = 1 in T2, TW and T3; it is 0 in T1 and T4.
- `R_OR_DT` = 1 from T1 through T4 of a read cycle; otherwise 0.
- Round robin: after granting master i, the highest-priority index becomes (i+1) mod NUM_MASTERS.
- Request changes while a cycle is granted are ignored; the cycle always completes.

## Timing
- Reset values:
  - state IDLE; `grant` = 0, `ack` = 0.
  - all command strobes = 1; `ALE` = 0, `IO_E` = 0, `R_OR_DT` = 0.
  - `bus_address` = 0, `bus_data_out` = 0, `rdata` = 0; round-robin pointer = 0.
- Reset asserted mid-cycle releases all strobes and the grant on that clock edge. No `ack` is issued.
- Minimum cycle length is 4 CPU clocks (T1..T4), plus one CPU clock per wait state and per extra `READY`-low posedge.
- `ack` rises on the same clock that T3 exits.
- A new request can start T1 on the posedge that follows T4, so back-to-back cycles have no idle gap.
- Posedge and negedge enables are never both 1 in one clock. If they are, the posedge action is taken and the negedge is ignored.
- Wait counter width is $clog2(MAX_WAIT+1). A parameter above MAX_WAIT is an elaboration error.

## Structure
- Package `bus_ctrl_pkg` holds:
  - `bus_state_t` enum (IDLE, T1, T2, TW, T3, T4);
  - `cycle_type_t` enum (IO_READ, IO_WRITE, MEM_READ, MEM_WRITE);
  - the strobe decode function.
- Sub-module `bus_grant_arbiter`: takes `req`, priority mode and pointer; returns a one-hot winner and the next pointer. It is purely combinational; the pointer register lives in the top level.

## Test plan
- Single CPU memory read, MEM_WAIT_STATES = 0, addr 0xF0000, `bus_data_in` = 0xA5:
  - `ALE` high for T1 only; `MEMR_N` low from the T2 negedge to T4 entry;
  - `rdata` = 0xA5 and `ack[0]` pulse after 4 CPU clocks.
- I/O write with IO_WAIT_STATES = 1, addr 0x0061, data 0x3C:
  - `IOW_N` low for T2+TW+T3; `IO_E` high in the same states; `bus_data_out` = 0x3C;
  - cycle takes 5 CPU clocks.
- `READY` held low for 3 posedges during a memory write: TW repeats 3 times; `MEMW_N` stays low throughout; cycle takes 7 CPU clocks.
- NUM_MASTERS = 3, `req` = 3'b111 held continuously:
  - ROUND_ROBIN = 0 → grants 0,0,0;
  - ROUND_ROBIN = 1 → grants 0,1,2,0 back-to-back with no idle state.
- Reset asserted in TW of an I/O read: next clock shows all strobes = 1, `grant` = 0, `ack` never pulses, state IDLE.
- `req[1]` dropped in T2: cycle still completes and `ack[1]` pulses.
